mult_div_seq: RTL and testbench
===============================

# mult_div_seq

Iterative signed multiply/divide sequencer that owns the CPU's HI and LO registers. The main control unit issues MULT or DIV with operands taken from registers A and B. The block runs a fixed 32-cycle radix-2 iteration, then signals completion. HI/LO then drive the HI and LO inputs of the register-data mux, replacing the current constant-zero wiring. A zero divisor raises a one-cycle exception flag; the control unit routes this to the divide-by-zero handler at address 255.

## Interface
- WIDTH, 32, operand width; HI, LO and the iteration count all equal WIDTH.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV; sampled with start.
- a_in  in  WIDTH  multiplicand or dividend (RegA_out).
- b_in  in  WIDTH  multiplier or divisor (RegB_out).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_zero  out  1  one-cycle pulse on DIV with b_in == 0.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

## Operation
- States:
  - IDLE -> RUN on start with a valid operation.
  - IDLE -> DZ on start with op=DIV and b_in == 0.
  - RUN -> FIN after WIDTH iterations.
  - FIN -> IDLE.
  - DZ -> IDLE.
- Reset values: state IDLE, iteration counter 0, busy 0, done 0, div_zero 0, hi_out 0, lo_out 0, all working registers 0.
- start is ignored outside IDLE: no queueing and no error.
- op, a_in and b_in are captured on the start edge; later changes have no effect.
- MULT:
  - Signed Booth radix-2.
  - 2*WIDTH+1-bit accumulator {upper, lower, q-1}.
  - One add/sub plus one arithmetic right shift per cycle.
  - Result: hi_out = product[63:32], lo_out = product[31:0].
- DIV:
  - Restoring division on magnitudes |a|, |b|; one shift/subtract per cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Result: lo_out = quotient, hi_out = remainder.
  - 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0. No overflow flag, no exception.
- Divide by zero:
  - No iterations run; hi_out and lo_out are unchanged.
  - div_zero = 1 for one cycle; done stays 0.
- hi_out and lo_out change only on the FIN-entry edge or on reset. They are never visible mid-iteration.
- Reset asserted mid-operation aborts immediately: next cycle is IDLE with all outputs at reset values.

## Timing
- start sampled at edge k:
  - busy = 1 during cycles k+1 .. k+32.
  - Iterations occur on edges k+1 .. k+32.
  - hi_out and lo_out update on edge k+32.
  - done = 1 during cycle k+32..k+33; busy = 0 in that cycle.
  - IDLE at edge k+33; a new start is accepted at edge k+33 or later.
- Total latency from start to done: 32 cycles (WIDTH generally).
- DZ path: div_zero = 1 during cycle k..k+1; IDLE at edge k+1.
- The control unit waits in a state until done or div_zero. It must not sample hi_out or lo_out before done.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared CPU package holds:
  - State encoding constants: IDLE, RUN, FIN, DZ.
  - Op constants: OP_MULT = 0, OP_DIV = 1.
  - The exception address constant 255, which is shared with the exception-address mux.
- One natural sub-module: md_abs_neg. It is combinational two's-complement absolute value and conditional negate. It is instantiated for operand magnitude and for quotient/remainder sign fix-up.
- The iteration counter is 6 bits, counting 0..31.

## Test plan
- MULT 7 x 0xFFFFFFFD (-3), start at edge k -> done at cycle k+32; hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB; busy high for exactly 32 cycles.
- MULT 0x7FFFFFFF x 0x7FFFFFFF -> hi_out = 0x3FFFFFFF, lo_out = 0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0; div_zero stays 0.
- DIV 5 / 0 with HI = 0x12, LO = 0x34 preloaded by a prior MULT:
  - div_zero pulses for one cycle after start; done stays 0; busy stays 0.
  - hi_out = 0x12, lo_out = 0x34 retained.
- Two interrupt cases, both on a MULT in flight:
  - start re-pulsed at iteration 5 -> ignored; result equals the uninterrupted case.
  - reset at iteration 10 -> next cycle busy = 0, hi_out = lo_out = 0; a following start runs normally.

Source files
------------

// File: rtl/mult_div_seq_pkg.sv
// Shared CPU constants for the multiply/divide sequencer: FSM states, op codes
// and the divide-by-zero exception vector.
package mult_div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DZ   = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Also consumed by the exception-address mux.
  localparam logic [7:0] EXC_ADDR = 8'd255;

endpackage

// File: rtl/mult_div_seq_abs_neg.sv
// Combinational two's-complement conditional negate; driving negate with the
// sign bit turns it into an absolute value.
module md_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed MULT (Booth radix-2) / DIV (restoring) sequencer owning the
// HI and LO registers; WIDTH iterations per operation.
module mult_div_seq
  import mult_div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2*WIDTH:0] acc_reg;
  logic [2*WIDTH:0] acc_next;
  logic [WIDTH-1:0] m_reg;
  logic             op_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;

  logic [WIDTH:0]   booth_upper;
  logic [WIDTH:0]   booth_m;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;

  logic [WIDTH-1:0] abs_in  [2];
  logic [WIDTH-1:0] abs_out [2];
  logic [WIDTH-1:0] fix_in  [2];
  logic [WIDTH-1:0] fix_out [2];
  logic [1:0]       fix_neg;

  // Index 0: a / LO (quotient), index 1: b / HI (remainder).
  assign abs_in[0] = a_in;
  assign abs_in[1] = b_in;
  assign fix_in[0] = acc_next[WIDTH:1];
  assign fix_in[1] = acc_next[2*WIDTH:WIDTH+1];
  assign fix_neg[0] = (op_reg == OP_DIV) && neg_q_reg;
  assign fix_neg[1] = (op_reg == OP_DIV) && neg_r_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sign
    md_abs_neg #(.WIDTH(WIDTH)) u_abs (
      .value  (abs_in[gi]),
      .negate (abs_in[gi][WIDTH-1]),
      .result (abs_out[gi])
    );
    md_abs_neg #(.WIDTH(WIDTH)) u_fix (
      .value  (fix_in[gi]),
      .negate (fix_neg[gi]),
      .result (fix_out[gi])
    );
  end

  // One iteration step. The Booth add is done one bit wider so that the
  // shifted-in sign survives operands such as the most negative value.
  always_comb begin
    booth_upper = {acc_reg[2*WIDTH], acc_reg[2*WIDTH:WIDTH+1]};
    booth_m     = {m_reg[WIDTH-1], m_reg};
    booth_sum   = booth_upper;
    div_shift   = acc_reg[2*WIDTH:WIDTH];
    div_trial   = {1'b0, div_shift} - {2'b00, m_reg};
    acc_next    = acc_reg;
    if (op_reg == OP_MULT) begin
      case (acc_reg[1:0])
        2'b01:   booth_sum = booth_upper + booth_m;
        2'b10:   booth_sum = booth_upper - booth_m;
        default: booth_sum = booth_upper;
      endcase
      acc_next = {booth_sum, acc_reg[WIDTH:1]};
    end else if (!div_trial[WIDTH+1]) begin
      acc_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-1:1], 1'b1, 1'b0};
    end else begin
      acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-1:1], 1'b0, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      m_reg     <= '0;
      op_reg    <= OP_MULT;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (op == OP_DIV && b_in == '0) begin
              state_reg <= DZ;
              div_zero  <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy      <= 1'b1;
              cnt_reg   <= '0;
              op_reg    <= op;
              neg_q_reg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              neg_r_reg <= a_in[WIDTH-1];
              if (op == OP_MULT) begin
                acc_reg <= {{WIDTH{1'b0}}, a_in, 1'b0};
                m_reg   <= b_in;
              end else begin
                acc_reg <= {{WIDTH{1'b0}}, abs_out[0], 1'b0};
                m_reg   <= abs_out[1];
              end
            end
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
          // Last iteration lands straight in HI/LO on the same edge.
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= FIN;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            lo_out    <= fix_out[0];
            hi_out    <= fix_out[1];
          end
        end
        FIN:     state_reg <= IDLE;
        DZ:      state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: directed vector table, interrupt sequences and random
// operations against a plain-arithmetic reference.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  always #5 clk = ~clk;

  mult_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers; returns {dz, hi, lo}.
  function automatic logic [64:0] ref_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] h, input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 1'b0) begin
      p = 64'(sa * sb);
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, h, l};
    q = sa / sb;
    r = sa % sb;
    qv = 64'(q);
    rv = 64'(r);
    return {1'b0, rv[31:0], qv[31:0]};
  endfunction

  // action: 0 plain, 1 re-pulse start at iteration 5, 2 reset at iteration 10
  task automatic run_op(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz,
                        input int action);
    int n, bcnt;
    logic dz_seen, early;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
    if (exp_dz) begin
      check({name, " dz_pulse"}, {61'd0, div_zero, busy, done}, 64'b100);
      @(posedge clk);
      #1;
      check({name, " dz_end"}, {62'd0, div_zero, done}, 64'd0);
      check({name, " dz_hold"}, {hi_out, lo_out}, {exp_hi, exp_lo});
      $display("op %s dz hi=0x%08h lo=0x%08h", name, hi_out, lo_out);
      return;
    end
    n = 0; bcnt = 0; dz_seen = 1'b0; early = 1'b0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      if (div_zero) dz_seen = 1'b1;
      if (hi_out !== cur_hi || lo_out !== cur_lo) early = 1'b1;
      if (action == 1 && n == 5) begin
        start = 1'b1; op = 1'b1; a_in = 32'd99; b_in = 32'd0;
      end
      if (action == 1 && n == 6) start = 1'b0;
      if (action == 2 && n == 10) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check({name, " reset_abort"}, {busy, done, div_zero, hi_out, lo_out}, 67'd0);
        cur_hi = '0; cur_lo = '0;
        $display("op %s reset at iteration 10 busy=%0b hi=0x%08h lo=0x%08h", name, busy, hi_out, lo_out);
        return;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd32);
    check({name, " busy_cycles"}, 64'(bcnt), 64'd32);
    check({name, " flags_at_done"}, {61'd0, busy, dz_seen, early}, 64'd0);
    check({name, " result"}, {hi_out, lo_out}, {exp_hi, exp_lo});
    $display("op %s a=0x%08h b=0x%08h hi=0x%08h lo=0x%08h cycles=%0d", name, a, b, hi_out, lo_out, n);
    cur_hi = exp_hi; cur_lo = exp_lo;
    @(posedge clk);
    #1;
    check({name, " done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [64:0] r;
    logic        ro;
    logic [31:0] ra, rb;

    vecs[0] = '{"mult_7_m3",    1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{"mult_max",     1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[2] = '{"div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{"div_min_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    // Sets HI=0x12, LO=0x34 so the divide-by-zero entry can show retention.
    vecs[4] = '{"div_preload",  1'b1, 32'h00003412, 32'h00000100, 32'h00000012, 32'h00000034, 1'b0};
    vecs[5] = '{"div_5_0",      1'b1, 32'd5,        32'd0,        32'h00000012, 32'h00000034, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, div_zero, hi_out, lo_out}, 67'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 0);

    run_op("mult_restart_ignored", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1);
    run_op("mult_reset_abort", 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b0, 2);
    run_op("mult_after_reset", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9)) - 32'd4;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      r = ref_op(ro, ra, rb, cur_hi, cur_lo);
      run_op($sformatf("rand%0d_%s", i, ro ? "div" : "mult"), ro, ra, rb, r[63:32], r[31:0], r[64], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
